// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory program loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } loader_state_t;

    localparam int WORD_BYTES = 4;

    function automatic logic [7:0] word_addr(input logic [7:0] idx, input logic [7:0] step);
        logic [15:0] w_prod;
        w_prod = idx * step;
        return w_prod[7:0];
    endfunction

endpackage

// File: rtl/imem_program_loader_word_assembler.sv
// Big-endian byte-to-word shift register; word_out/word_full include the byte
// being loaded this cycle so the caller can register the full word on the 4th byte.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        load_en,
    input  logic [7:0]  byte_in,
    input  logic        flush,
    output logic [31:0] word_out,
    output logic        word_full
);

    logic [23:0] r_word;
    logic [1:0]  r_cnt;

    always_ff @(posedge clk) begin
        if (clr || flush) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (load_en) begin
            r_word <= {r_word[15:0], byte_in};
            r_cnt  <= r_cnt + 2'd1;
        end
    end

    assign word_out  = {r_word, byte_in};
    assign word_full = load_en && (r_cnt == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_program_loader.sv
// Instruction-memory program loader: count byte N, then 4N big-endian data bytes.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_program_loader
    import imem_loader_pkg::*;
#(
    parameter int MAX_WORDS = 64,
    parameter int ADDR_STEP = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imu_wen,
    output logic [7:0]  imu_addr,
    output logic [31:0] imu_data_in,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [8:0] MAXW9 = 9'(MAX_WORDS);
    localparam logic [7:0] STEP8 = 8'(ADDR_STEP);

    loader_state_t r_state;
    logic [7:0]    r_count;
    logic [7:0]    r_word_idx;
    logic          r_byte_ready;
    logic          r_imu_wen;
    logic [7:0]    r_imu_addr;
    logic [31:0]   r_imu_data;
    logic          r_cpu_hold;
    logic          r_busy;
    logic          r_done;
    logic          r_error;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    r_csum;
`endif

    logic        w_xfer;
    logic        w_accept_start;
    logic        w_bad_count;
    logic [31:0] w_word;
    logic        w_word_full;

    assign w_xfer         = byte_valid && r_byte_ready;
    assign w_accept_start = start && (r_state == IDLE || r_state == DONE || r_state == ERROR);
    assign w_bad_count    = (byte_data == 8'd0) || ({1'b0, byte_data} > MAXW9);

    word_assembler u_asm (
        .clk       (clk),
        .clr       (clr),
        .load_en   (w_xfer && (r_state == DATA)),
        .byte_in   (byte_data),
        .flush     (w_accept_start),
        .word_out  (w_word),
        .word_full (w_word_full)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_word_idx   <= '0;
            r_byte_ready <= 1'b0;
            r_imu_wen    <= 1'b0;
            r_imu_addr   <= '0;
            r_imu_data   <= '0;
            r_cpu_hold   <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            r_imu_wen <= 1'b0;
            case (r_state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        r_state      <= COUNT;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_error      <= 1'b0;
                        r_cpu_hold   <= 1'b1;
                        r_byte_ready <= 1'b1;
                        r_word_idx   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum       <= '0;
`endif
                    end
                end
                COUNT: begin
                    if (w_xfer) begin
                        if (w_bad_count) begin
                            r_state      <= ERROR;
                            r_byte_ready <= 1'b0;
                            r_busy       <= 1'b0;
                            r_error      <= 1'b1;
                        end else begin
                            r_state <= DATA;
                            r_count <= byte_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_csum  <= byte_data;
`endif
                        end
                    end
                end
                DATA: begin
                    if (w_xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum <= r_csum ^ byte_data;
`endif
                        if (w_word_full) begin
                            r_state      <= WRITE;
                            r_byte_ready <= 1'b0;
                            r_imu_wen    <= 1'b1;
                            r_imu_addr   <= word_addr(r_word_idx, STEP8);
                            r_imu_data   <= w_word;
                        end
                    end
                end
                WRITE: begin
                    r_word_idx <= r_word_idx + 8'd1;
                    if (r_word_idx == r_count - 8'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_state      <= CHECK;
                        r_byte_ready <= 1'b1;
`else
                        r_state      <= DONE;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_cpu_hold   <= 1'b0;
`endif
                    end else begin
                        r_state      <= DATA;
                        r_byte_ready <= 1'b1;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (w_xfer) begin
                        r_byte_ready <= 1'b0;
                        r_busy       <= 1'b0;
                        if (byte_data == r_csum) begin
                            r_state    <= DONE;
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_state <= ERROR;
                            r_error <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    r_state      <= IDLE;
                    r_byte_ready <= 1'b0;
                    r_busy       <= 1'b0;
                    r_cpu_hold   <= 1'b1;
                end
            endcase
        end
    end

    assign byte_ready  = r_byte_ready;
    assign imu_wen     = r_imu_wen;
    assign imu_addr    = r_imu_addr;
    assign imu_data_in = r_imu_data;
    assign cpu_hold    = r_cpu_hold;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader with a write scoreboard; covers the
// checksum trailer when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_program_loader;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imu_wen;
    logic [7:0]  imu_addr;
    logic [31:0] imu_data_in;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;
    int unsigned wen_count  = 0;
    logic [39:0] exp_q[$];
    logic [31:0] words[0:3];

    imem_program_loader #(.MAX_WORDS(64), .ADDR_STEP(4)) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .imu_wen     (imu_wen),
        .imu_addr    (imu_addr),
        .imu_data_in (imu_data_in),
        .cpu_hold    (cpu_hold),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Write monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [39:0] e;
        if (imu_wen === 1'b1) begin
            wen_count++;
            vectors++;
            assert (byte_ready === 1'b0) else begin
                miscompares++;
                $error("FAIL ready_in_write: observed %b expected 0", byte_ready);
            end
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL unexpected_write: observed addr %h data %h expected no write", imu_addr, imu_data_in);
            end else begin
                e = exp_q.pop_front();
                vectors++;
                assert ({imu_addr, imu_data_in} === e) else begin
                    miscompares++;
                    $error("FAIL write: observed %h/%h expected %h/%h", imu_addr, imu_data_in, e[39:32], e[31:0]);
                end
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge following the transfer edge.
    task automatic send_byte(input logic [7:0] b, input bit bp);
        int unsigned t;
        if (bp) repeat ($urandom_range(0, 2)) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        t = 0;
        while (byte_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            vectors++;
            miscompares++;
            $error("FAIL ready_timeout: observed byte_ready %b expected 1", byte_ready);
        end else begin
            @(negedge clk);
        end
        byte_valid = 1'b0;
        if (bp && $urandom_range(0, 1) == 1) @(negedge clk);
    endtask

    task automatic wait_idle();
        int unsigned t;
        t = 0;
        while (busy === 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("busy_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic load(input int n, input bit bp, input bit bad_csum, input bit poke_start);
        logic [7:0] cs;
        logic [7:0] b;
        logic [31:0] w;
        cs = n[7:0];
        do_start();
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_hold", {31'd0, cpu_hold}, 32'd1);
        chk("start_done_clr", {30'd0, done, error}, 32'd0);
        send_byte(n[7:0], bp);
        for (int i = 0; i < n; i++) begin
            w = words[i];
            exp_q.push_back({8'(i * 4), w});
            for (int j = 0; j < 4; j++) begin
                b = w[31 - 8 * j -: 8];
                cs = cs ^ b;
                send_byte(b, bp);
            end
            if (poke_start && i == 0) do_start();
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(bad_csum ? (cs ^ 8'h01) : cs, bp);
`else
        if (bad_csum) $error("FAIL bench_config: observed checksum request expected none");
`endif
        wait_idle();
    endtask

    initial begin
        int unsigned w0;
        clr        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_outputs", {24'd0, byte_ready, imu_wen, cpu_hold, busy, done, error, 2'b00}, {24'd0, 8'b0010_0000});
        chk("rst_addr", {24'd0, imu_addr}, 32'd0);
        chk("rst_data", imu_data_in, 32'd0);
        clr = 1'b0;
        @(negedge clk);
        chk("idle_hold", {31'd0, cpu_hold}, 32'd1);

        // Basic two-word load.
        words[0] = 32'h2008_0005;
        words[1] = 32'h0109_5020;
        load(2, 1'b0, 1'b0, 1'b0);
        chk("basic_done", {29'd0, done, cpu_hold, error}, 32'b100);
        chk("basic_drain", exp_q.size(), 32'd0);

        // Bad counts: zero and above MAX_WORDS.
        w0 = wen_count;
        do_start();
        send_byte(8'h00, 1'b0);
        chk("cnt0_error", {29'd0, error, cpu_hold, busy}, 32'b110);
        do_start();
        chk("cnt_restart_err_clr", {31'd0, error}, 32'd0);
        send_byte(8'h41, 1'b0);
        chk("cnt65_error", {29'd0, error, cpu_hold, busy}, 32'b110);
        chk("cnt_ready", {31'd0, byte_ready}, 32'd0);
        repeat (3) @(negedge clk);
        chk("cnt_no_write", wen_count, w0);

        // Randomised backpressure, three words.
        words[0] = 32'hA1B2_C3D4;
        words[1] = 32'h0F1E_2D3C;
        words[2] = 32'h5566_7788;
        load(3, 1'b1, 1'b0, 1'b0);
        chk("bp_done", {30'd0, done, error}, 32'b10);
        chk("bp_drain", exp_q.size(), 32'd0);

        // Reset after the sixth byte: word 0 is already written.
        do_start();
        exp_q.push_back({8'h00, 32'h1111_1111});
        send_byte(8'h02, 1'b0);
        repeat (4) send_byte(8'h11, 1'b0);
        send_byte(8'hAA, 1'b0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_state", {29'd0, cpu_hold, busy, byte_ready}, 32'b100);
        chk("clr_flags", {30'd0, done, error}, 32'd0);
        words[0] = 32'hDEAD_BEEF;
        load(1, 1'b0, 1'b0, 1'b0);
        chk("clr_reload_done", {30'd0, done, cpu_hold}, 32'b10);
        chk("clr_drain", exp_q.size(), 32'd0);

        // Restart from DONE with a start pulse while busy.
        words[0] = 32'h0000_0013;
        words[1] = 32'hFFFF_FFFF;
        load(2, 1'b0, 1'b0, 1'b1);
        chk("restart_done", {29'd0, done, cpu_hold, error}, 32'b100);
        chk("restart_drain", exp_q.size(), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        words[0] = 32'h1122_3344;
        load(1, 1'b0, 1'b0, 1'b0);
        chk("csum_ok", {29'd0, done, cpu_hold, error}, 32'b100);
        load(1, 1'b0, 1'b1, 1'b0);
        chk("csum_bad", {29'd0, done, cpu_hold, error}, 32'b011);
        chk("csum_drain", exp_q.size(), 32'd0);
`endif

        repeat (3) @(negedge clk);
        chk("final_drain", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
